// File: rtl/mvm_operand_sequencer.sv
// Streaming operand assembler for the matrix-vector multiplier: collects one
// frame of matrix/vector words, holds them for one evaluate cycle, and returns
// the multiplier's scalar result over a valid/ready handshake.
module mvm_operand_sequencer #(
    parameter int DATA_W = 32,
    parameter int ROWS   = 3,
    parameter int COLS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [DATA_W-1:0] mat_o [ROWS][COLS],
    output logic [DATA_W-1:0] vec_o [COLS],
    input  logic [DATA_W-1:0] mvm_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_err
);

    localparam int MAT_N     = ROWS * COLS;
    localparam int FRAME_LEN = MAT_N + COLS;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]       state_r;
    logic [IDX_W-1:0] idx_r;
    logic             accept_s;
    logic             at_last_s;
    logic             framing_err_s;

    // Ready only while loading; forced low during reset.
    assign in_ready = (state_r == ST_LOAD) && !rst;

    // Accept decode and framing check: the last flag must coincide with the final index.
    always_comb begin
        accept_s      = in_valid && in_ready;
        at_last_s     = (idx_r == LAST_IDX);
        framing_err_s = accept_s && (in_last != at_last_s);
    end

    // Frame FSM, word index, result capture and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_LOAD;
            idx_r     <= {IDX_W{1'b0}};
            out_data  <= {DATA_W{1'b0}};
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= framing_err_s;
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) begin
                        if (framing_err_s) begin
                            idx_r <= {IDX_W{1'b0}};
                        end else if (at_last_s) begin
                            idx_r   <= {IDX_W{1'b0}};
                            state_r <= ST_EVAL;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                ST_EVAL: begin
                    out_data  <= mvm_result;
                    out_valid <= 1'b1;
                    state_r   <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= ST_LOAD;
                    end
                end
                default: begin
                    state_r   <= ST_LOAD;
                    idx_r     <= {IDX_W{1'b0}};
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Operand registers: each accepted word lands at its row-major slot, then the vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mat_o[r][c] <= {DATA_W{1'b0}};
                end
            end
            for (int c = 0; c < COLS; c++) begin
                vec_o[c] <= {DATA_W{1'b0}};
            end
        end else if (accept_s) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (idx_r == IDX_W'(r * COLS + c)) begin
                        mat_o[r][c] <= in_data;
                    end
                end
            end
            for (int c = 0; c < COLS; c++) begin
                if (idx_r == IDX_W'(MAT_N + c)) begin
                    vec_o[c] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mvm_operand_sequencer.sv
// Self-checking bench for mvm_operand_sequencer: table-driven frames, hand-written
// timing/backpressure/framing/reset sequences, and randomized frames vs a reference.
module tb_mvm_operand_sequencer;

    localparam int DW = 32;
    localparam int R  = 3;
    localparam int C  = 4;
    localparam int FL = R * C + C;

    typedef logic [FL-1:0][DW-1:0] frame_t;
    typedef struct packed {
        frame_t        words;
        logic [DW-1:0] expected;
    } vector_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic [DW-1:0] mat_o [R][C];
    logic [DW-1:0] vec_o [C];
    logic [DW-1:0] mvm_result;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          frame_err;

    int tests = 0;
    int fails = 0;

    mvm_operand_sequencer #(.DATA_W(DW), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mat_o(mat_o), .vec_o(vec_o), .mvm_result(mvm_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Combinational multiplier stand-in: sum of all elements of mat*vec.
    always_comb begin
        mvm_result = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                mvm_result = mvm_result + mat_o[r][c] * vec_o[c];
    end

    function automatic logic [DW-1:0] ref_result(input frame_t w);
        logic [DW-1:0] acc;
        acc = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                acc = acc + w[r*C+c] * w[R*C+c];
        return acc;
    endfunction

    function automatic logic operands_nonzero();
        logic any;
        any = 1'b0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                any = any | (|mat_o[r][c]);
        for (int c = 0; c < C; c++)
            any = any | (|vec_o[c]);
        return any;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic bubble();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = $urandom_range(0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input frame_t w, input bit bubbles);
        for (int i = 0; i < FL; i++) begin
            if (bubbles && ($urandom_range(0, 1) == 1)) bubble();
            send_word(w[i], (i == FL - 1));
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    // Collect one result with out_ready high and confirm the handshake clears out_valid.
    task automatic collect(input string name, input logic [DW-1:0] exp);
        out_ready = 1'b1;
        @(negedge clk);
        wait_valid();
        check(name, out_data, exp);
        @(posedge clk);
        #1;
        check({name, "_handshake"}, 32'(out_valid), 32'd0);
    endtask

    vector_t tbl [4];
    frame_t  f;
    logic [DW-1:0] held;

    initial begin
        // Test-plan frames as table entries.
        for (int i = 0; i < FL; i++) f[i] = (i < R*C) ? DW'(i) : 32'd1;
        tbl[0] = '{words: f, expected: 32'd66};
        for (int i = 0; i < FL; i++) f[i] = (i < R*C) ? 32'd1 : DW'(i - R*C + 1);
        tbl[1] = '{words: f, expected: 32'd30};
        for (int i = 0; i < FL; i++) f[i] = 32'd0;
        f[0] = 32'hFFFF_FFFF;
        f[R*C] = 32'd2;
        tbl[2] = '{words: f, expected: 32'hFFFF_FFFE};
        for (int i = 0; i < FL; i++) f[i] = (i < R*C) ? 32'd2 : 32'd3;
        tbl[3] = '{words: f, expected: 32'd72};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_operands", 32'(operands_nonzero()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Table-driven frames.
        for (int t = 0; t < 4; t++) begin
            send_frame(tbl[t].words, 1'b0);
            collect($sformatf("tbl%0d", t), tbl[t].expected);
        end

        // Exact latency: EVAL cycle, then out_valid, in_ready low for two cycles.
        out_ready = 1'b1;
        send_frame(tbl[0].words, 1'b0);
        @(negedge clk);
        check("lat_eval_valid", 32'(out_valid), 32'd0);
        check("lat_eval_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_out_data", out_data, 32'd66);
        check("lat_out_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("lat_back_valid", 32'(out_valid), 32'd0);
        check("lat_back_ready", 32'(in_ready), 32'd1);

        // Backpressure for 10 cycles.
        out_ready = 1'b0;
        send_frame(tbl[1].words, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", out_data, 32'd30);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'(out_valid), 32'd0);

        // Early last flag on word 7.
        for (int i = 0; i < 8; i++) send_word(32'd5, (i == 7));
        check("early_last_err", 32'(frame_err), 32'd1);
        @(posedge clk); #1;
        check("early_last_pulse", 32'(frame_err), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("early_last_no_valid", 32'(out_valid), 32'd0);
        end
        send_frame(tbl[3].words, 1'b0);
        collect("after_err", 32'd72);

        // Missing last flag at the final index.
        for (int i = 0; i < FL; i++) send_word(32'd7, 1'b0);
        check("missing_last_err", 32'(frame_err), 32'd1);
        @(negedge clk); @(negedge clk);
        check("missing_last_no_valid", 32'(out_valid), 32'd0);
        send_frame(tbl[1].words, 1'b0);
        collect("after_missing", 32'd30);

        // Bubbled frame matches the gap-free result.
        send_frame(tbl[0].words, 1'b1);
        collect("bubbles", 32'd66);

        // Reset at word 9, then a clean frame.
        for (int i = 0; i < 9; i++) send_word(32'd9, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_operands", 32'(operands_nonzero()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(tbl[3].words, 1'b0);
        collect("post_midrst", 32'd72);

        // Reset while holding a result in OUT.
        out_ready = 1'b0;
        send_frame(tbl[1].words, 1'b0);
        @(negedge clk);
        wait_valid();
        rst = 1'b1;
        @(posedge clk); #1;
        check("outrst_valid", 32'(out_valid), 32'd0);
        check("outrst_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // Randomized frames with bubbles and random backpressure.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < FL; i++)
                f[i] = (t % 3 == 0) ? DW'($urandom) : DW'($urandom_range(0, 1000));
            out_ready = 1'b0;
            send_frame(f, 1'b1);
            @(negedge clk);
            wait_valid();
            held = out_data;
            check($sformatf("rand%0d", t), out_data, ref_result(f));
            for (int k = 0; k < $urandom_range(0, 4); k++) begin
                @(negedge clk);
                check("rand_hold", out_data, held);
            end
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk); #1;
            check("rand_handshake", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
